// File: rtl/dmem_pkg.sv
// Shared definitions for the DMEM responder: timer register map, CTRL bits,
// timer state encoding and the request payload seen on the core's DMEM port.
package dmem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned SEL_W  = DATA_W / 8;
  localparam int unsigned PRESC_W = 16;

  // Byte offsets inside the 16-byte timer window
  localparam logic [3:0] TMR_OFF_COUNT   = 4'h0;
  localparam logic [3:0] TMR_OFF_COMPARE = 4'h4;
  localparam logic [3:0] TMR_OFF_CTRL    = 4'h8;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_AUTO  = 1;
  localparam int unsigned CTRL_PEND  = 2;
  localparam int unsigned CTRL_ST_LO = 3;
  localparam int unsigned CTRL_ST_HI = 4;

  localparam logic [1:0] TMR_IDLE  = 2'b00;
  localparam logic [1:0] TMR_RUN   = 2'b01;
  localparam logic [1:0] TMR_FIRED = 2'b10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [SEL_W-1:0]  sel;
  } dmem_req_t;

  // Replace the selected byte lanes of a word with the new write data
  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old_word,
                                                   input logic [DATA_W-1:0] wdata,
                                                   input logic [SEL_W-1:0]  sel);
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int n = 0; n < int'(SEL_W); n++) begin
      if (sel[n]) merged[8*n +: 8] = wdata[8*n +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_timer.sv
// Count/compare timer: prescaler, COUNT/COMPARE/CTRL registers, IDLE/RUN/FIRED
// state machine and the level interrupt (the PEND flag).
module dmem_timer
  import dmem_pkg::*;
#(
  parameter int unsigned TMR_DIV = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we,
  input  logic [3:0]        off,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c,
  output logic              timer_int
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TMR_DIV - 1);

  logic [DATA_W-1:0]  count, count_n;
  logic [DATA_W-1:0]  compare, compare_n;
  logic [PRESC_W-1:0] presc, presc_n;
  logic [1:0]         state, state_n;
  logic               en, en_n;
  logic               auto_rl, auto_n;
  logic               pend, pend_n;

  logic               wr_count, wr_compare, wr_ctrl;
  logic               tick, match;
  logic [DATA_W-1:0]  count_inc;

  assign wr_count   = we && (off == TMR_OFF_COUNT);
  assign wr_compare = we && (off == TMR_OFF_COMPARE);
  assign wr_ctrl    = we && (off == TMR_OFF_CTRL);

  assign count_inc = count + DATA_W'(1);
  assign tick      = (state == TMR_RUN) && (presc == PRESC_LAST);
  // The match uses the COMPARE value held before any write in this cycle
  assign match     = tick && (count_inc == compare);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count   <= '0;
      compare <= '1;
      presc   <= '0;
      state   <= TMR_IDLE;
      en      <= 1'b0;
      auto_rl <= 1'b0;
      pend    <= 1'b0;
    end else begin
      count   <= count_n;
      compare <= compare_n;
      presc   <= presc_n;
      state   <= state_n;
      en      <= en_n;
      auto_rl <= auto_n;
      pend    <= pend_n;
    end
  end

  always_comb begin
    count_n   = count;
    compare_n = compare;
    presc_n   = presc;
    state_n   = state;
    en_n      = en;
    auto_n    = auto_rl;
    pend_n    = pend;

    case (state)
      TMR_IDLE: ;
      TMR_RUN: begin
        presc_n = tick ? '0 : presc + PRESC_W'(1);
        if (tick) begin
          count_n = (match && auto_rl) ? '0 : count_inc;
          if (match && !auto_rl) state_n = TMR_FIRED;
        end
      end
      TMR_FIRED: begin
        if (wr_count || wr_compare) state_n = TMR_RUN;
      end
      default: state_n = TMR_IDLE;
    endcase

    // A match in the same cycle as a W1C write wins
    if (wr_ctrl && wdata[CTRL_PEND]) pend_n = 1'b0;
    if (match) pend_n = 1'b1;

    // Software COUNT write overrides the increment
    if (wr_count)   count_n   = wdata;
    if (wr_compare) compare_n = wdata;

    if (wr_ctrl) begin
      en_n   = wdata[CTRL_EN];
      auto_n = wdata[CTRL_AUTO];
      if (!wdata[CTRL_EN]) begin
        state_n = TMR_IDLE;
        presc_n = '0;
      end else if (state != TMR_RUN) begin
        state_n = TMR_RUN;
      end
    end
  end

  always_comb begin
    rdata_c = '0;
    case (off)
      TMR_OFF_COUNT:   rdata_c = count;
      TMR_OFF_COMPARE: rdata_c = compare;
      TMR_OFF_CTRL: begin
        rdata_c[CTRL_EN]               = en;
        rdata_c[CTRL_AUTO]             = auto_rl;
        rdata_c[CTRL_PEND]             = pend;
        rdata_c[CTRL_ST_HI:CTRL_ST_LO] = state;
      end
      default: rdata_c = '0;
    endcase
  end

  assign timer_int = pend;

endmodule

// File: rtl/dmem_responder.sv
// DMEM-port responder: address decode, byte-writable word RAM and read mux.
// The count/compare timer is built only when DMEM_RESPONDER_TIMER_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 2048,
  parameter logic [31:0] RAM_BASE  = 32'h1001_0000,
  parameter logic [31:0] TMR_BASE  = 32'hFFFF_0000,
  parameter int unsigned TMR_DIV   = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_we,
  input  logic [SEL_W-1:0]  i_sel,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_bad_access,
  output logic              o_timer_int
);

  localparam int unsigned IDX_W  = $clog2(RAM_WORDS);
  localparam int unsigned RAM_AW = IDX_W + 2;

  dmem_req_t         req;
  logic              ram_hit;
  logic [IDX_W-1:0]  ram_idx;
  logic [DATA_W-1:0] ram_word;
  logic [DATA_W-1:0] mem [RAM_WORDS];

  assign req = '{addr: i_addr, wdata: i_wdata, we: i_we, sel: i_sel};

  assign ram_hit  = (req.addr[ADDR_W-1:RAM_AW] == RAM_BASE[ADDR_W-1:RAM_AW]);
  assign ram_idx  = req.addr[RAM_AW-1:2];
  assign ram_word = mem[ram_idx];

  // RAM contents survive reset, so this array has no reset branch
  always_ff @(posedge clk) begin
    if (ram_hit && req.we) begin
      mem[ram_idx] <= lane_merge(mem[ram_idx], req.wdata, req.sel);
    end
  end

`ifdef DMEM_RESPONDER_TIMER_EN
  logic              tmr_hit;
  logic              tmr_ok;
  logic              tmr_we;
  logic [DATA_W-1:0] tmr_rdata;

  // RAM decode takes priority should the two windows ever overlap
  assign tmr_hit = !ram_hit && (req.addr[ADDR_W-1:4] == TMR_BASE[ADDR_W-1:4]);
  assign tmr_ok  = tmr_hit && (req.addr[1:0] == 2'b00);
  assign tmr_we  = tmr_ok && req.we && (req.sel == '1);

  dmem_timer #(
    .TMR_DIV (TMR_DIV)
  ) u_timer (
    .clk       (clk),
    .resetn    (resetn),
    .we        (tmr_we),
    .off       (req.addr[3:0]),
    .wdata     (req.wdata),
    .rdata_c   (tmr_rdata),
    .timer_int (o_timer_int)
  );

  always_comb begin
    o_rdata      = '0;
    o_bad_access = 1'b1;
    if (ram_hit) begin
      o_rdata      = ram_word;
      o_bad_access = 1'b0;
    end else if (tmr_ok) begin
      o_rdata      = tmr_rdata;
      o_bad_access = 1'b0;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{TMR_BASE, 16'(TMR_DIV), req.addr[1:0]};

  assign o_timer_int = 1'b0;

  always_comb begin
    o_rdata      = '0;
    o_bad_access = 1'b1;
    if (ram_hit) begin
      o_rdata      = ram_word;
      o_bad_access = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: two instances (TMR_DIV 1 and 4) share
// one request bus; RAM expectations come from a word model, reads via a queue.
module tb_dmem_responder;

  localparam logic [31:0] RB        = 32'h1001_0000;
  localparam logic [31:0] TB        = 32'hFFFF_0000;
  localparam logic [31:0] RAM_BYTES = 32'h0000_2000;

  logic        clk;
  logic        resetn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] rdata1, rdata4;
  logic        bad1, bad4;
  logic        int1, int4;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_q [$];
  logic [31:0] model [int];

  dmem_responder #(.RAM_WORDS(2048), .RAM_BASE(RB), .TMR_BASE(TB), .TMR_DIV(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .i_addr(addr), .i_wdata(wdata), .i_we(we), .i_sel(sel),
    .o_rdata(rdata1), .o_bad_access(bad1), .o_timer_int(int1)
  );

  dmem_responder #(.RAM_WORDS(2048), .RAM_BASE(RB), .TMR_BASE(TB), .TMR_DIV(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .i_addr(addr), .i_wdata(wdata), .i_we(we), .i_sel(sel),
    .o_rdata(rdata4), .o_bad_access(bad4), .o_timer_int(int4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_ram(input logic [31:0] a);
    return (a >= RB) && (a < RB + RAM_BYTES);
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int i;
    i = int'((a - RB) >> 2);
    return model.exists(i) ? model[i] : 32'h0;
  endfunction

  // One bus write cycle; returns 1ns after the edge where it lands
  task automatic cyc_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    addr = a; wdata = d; we = 1'b1; sel = s;
    if (is_ram(a)) begin
      m = model_rd(a);
      for (int n = 0; n < 4; n++) if (s[n]) m[8*n +: 8] = d[8*n +: 8];
      model[int'((a - RB) >> 2)] = m;
    end
    @(posedge clk); #1;
    we = 1'b0; sel = 4'h0;
  endtask

  task automatic test_reset;
    logic [31:0] e;
    @(negedge clk);
    n_checks++;
    if (int1 !== 1'b0 || int4 !== 1'b0) begin
      n_fail++; $display("FAIL reset_int: got %b/%b expected 0/0", int1, int4);
    end
`ifdef DMEM_RESPONDER_TIMER_EN
    addr = TB + 32'h8; we = 1'b0; exp_q.push_back(32'h0);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++;
    if (rdata1 !== e || bad1 !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %h bad=%b expected %h bad=0", rdata1, bad1, e);
    end
    addr = TB + 32'h4; exp_q.push_back(32'hFFFF_FFFF);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++;
    if (rdata1 !== e || rdata4 !== e) begin
      n_fail++; $display("FAIL reset_compare: got %h/%h expected %h", rdata1, rdata4, e);
    end
    addr = TB; exp_q.push_back(32'h0);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++;
    if (rdata1 !== e) begin
      n_fail++; $display("FAIL reset_count: got %h expected %h", rdata1, e);
    end
`else
    addr = TB; we = 1'b0; exp_q.push_back(32'h0);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++;
    if (rdata1 !== e || bad1 !== 1'b1) begin
      n_fail++; $display("FAIL reset_tmr_unmapped: got %h bad=%b expected %h bad=1", rdata1, bad1, e);
    end
`endif
  endtask

  task automatic test_byte_lanes;
    logic [31:0] e;
    cyc_write(RB + 32'h4, 32'hAABB_CCDD, 4'b1111);
    cyc_write(RB + 32'h4, 32'h0000_1100, 4'b0010);
    addr = RB + 32'h4; exp_q.push_back(model_rd(RB + 32'h4));
    @(negedge clk); e = exp_q.pop_front();
    n_checks++;
    if (rdata1 !== e || rdata4 !== e || bad1 !== 1'b0) begin
      n_fail++; $display("FAIL byte_lanes: got %h/%h bad=%b expected %h bad=0", rdata1, rdata4, bad1, e);
    end
    n_checks++;
    if (rdata1 !== 32'hAABB_11DD) begin
      n_fail++; $display("FAIL byte_lanes_value: got %h expected aabb11dd", rdata1);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] e;
    @(posedge clk); #1;
    addr = RB + 32'h4; wdata = 32'h1234_5678; we = 1'b1; sel = 4'hF;
    exp_q.push_back(model_rd(RB + 32'h4));
    @(negedge clk); e = exp_q.pop_front();
    n_checks++;
    if (rdata1 !== e) begin
      n_fail++; $display("FAIL same_cycle_old: got %h expected %h", rdata1, e);
    end
    model[1] = 32'h1234_5678;
    @(posedge clk); #1;
    we = 1'b0; sel = 4'h0;
    exp_q.push_back(model_rd(RB + 32'h4));
    @(negedge clk); e = exp_q.pop_front();
    n_checks++;
    if (rdata1 !== e) begin
      n_fail++; $display("FAIL next_cycle_new: got %h expected %h", rdata1, e);
    end
    cyc_write(RB + RAM_BYTES - 32'h4, 32'hCAFE_F00D, 4'hF);
    cyc_write(RB, 32'h0BAD_F00D, 4'hF);
    addr = RB + RAM_BYTES - 32'h4; exp_q.push_back(model_rd(RB + RAM_BYTES - 32'h4));
    @(negedge clk); e = exp_q.pop_front();
    n_checks++;
    if (rdata1 !== e || bad1 !== 1'b0) begin
      n_fail++; $display("FAIL ram_top_word: got %h bad=%b expected %h bad=0", rdata1, bad1, e);
    end
  endtask

  task automatic test_unmapped;
    logic [31:0] e;
    addr = 32'h0; we = 1'b0; exp_q.push_back(32'h0);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++;
    if (rdata1 !== e || bad1 !== 1'b1) begin
      n_fail++; $display("FAIL unmapped_read: got %h bad=%b expected %h bad=1", rdata1, bad1, e);
    end
    cyc_write(32'h0, 32'hFFFF_FFFF, 4'hF);
    cyc_write(32'h2001_0000, 32'hFFFF_FFFF, 4'hF);
    addr = RB; exp_q.push_back(model_rd(RB));
    @(negedge clk); e = exp_q.pop_front();
    n_checks++;
    if (rdata1 !== e) begin
      n_fail++; $display("FAIL unmapped_write_dropped: got %h expected %h", rdata1, e);
    end
    addr = TB + 32'h2;
    @(negedge clk);
    n_checks++;
    if (bad1 !== 1'b1 || rdata1 !== 32'h0) begin
      n_fail++; $display("FAIL tmr_misaligned: got bad=%b rdata=%h expected bad=1 rdata=0", bad1, rdata1);
    end
    addr = TB + 32'h10;
    @(negedge clk);
    n_checks++;
    if (bad4 !== 1'b1) begin
      n_fail++; $display("FAIL tmr_window_end: got bad=%b expected 1", bad4);
    end
    addr = RB - 32'h4;
    @(negedge clk);
    n_checks++;
    if (bad1 !== 1'b1) begin
      n_fail++; $display("FAIL below_ram: got bad=%b expected 1", bad1);
    end
    addr = RB + RAM_BYTES;
    @(negedge clk);
    n_checks++;
    if (bad1 !== 1'b1) begin
      n_fail++; $display("FAIL above_ram: got bad=%b expected 1", bad1);
    end
  endtask

`ifdef DMEM_RESPONDER_TIMER_EN
  task automatic test_oneshot;
    logic [31:0] e;
    cyc_write(TB + 32'h8, 32'h0, 4'hF);
    cyc_write(TB, 32'h0, 4'hF);
    cyc_write(TB + 32'h4, 32'd5, 4'hF);
    cyc_write(TB + 32'h8, 32'h1, 4'hF);
    addr = TB;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back((k >= 5) ? 32'd5 : 32'(k));
      @(negedge clk); e = exp_q.pop_front();
      n_checks++;
      if (rdata1 !== e || int1 !== (k >= 5)) begin
        n_fail++; $display("FAIL oneshot_k%0d: count=%h int=%b expected count=%h int=%b", k, rdata1, int1, e, (k >= 5));
      end
    end
    addr = TB + 32'h8; exp_q.push_back(32'h15);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++;
    if (rdata1 !== e) begin
      n_fail++; $display("FAIL oneshot_fired_ctrl: got %h expected %h", rdata1, e);
    end
    cyc_write(TB + 32'h4, 32'h0, 4'b0001);
    addr = TB + 32'h4; exp_q.push_back(32'd5);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++;
    if (rdata1 !== e) begin
      n_fail++; $display("FAIL partial_tmr_write: compare=%h expected %h", rdata1, e);
    end
    cyc_write(TB + 32'h8, 32'h5, 4'hF);
    exp_q.push_back(32'h09);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++;
    if (rdata1 !== e || int1 !== 1'b0) begin
      n_fail++; $display("FAIL pend_clear_rerun: ctrl=%h int=%b expected ctrl=%h int=0", rdata1, int1, e);
    end
  endtask

  task automatic test_count_write;
    logic [31:0] e;
    cyc_write(TB, 32'd100, 4'hF);
    addr = TB; exp_q.push_back(32'd100);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++;
    if (rdata1 !== e || rdata4 !== e) begin
      n_fail++; $display("FAIL count_write_priority: got %h/%h expected %h", rdata1, rdata4, e);
    end
    exp_q.push_back(32'd101);
    @(negedge clk); e = exp_q.pop_front();
    n_checks++;
    if (rdata1 !== e) begin
      n_fail++; $display("FAIL count_after_write: got %h expected %h", rdata1, e);
    end
  endtask

  task automatic test_auto_reload;
    logic [31:0] e;
    bit          chk;
    bit          exp_int;
    cyc_write(TB + 32'h8, 32'h0, 4'hF);
    cyc_write(TB, 32'h0, 4'hF);
    cyc_write(TB + 32'h4, 32'd3, 4'hF);
    cyc_write(TB + 32'h8, 32'h3, 4'hF);
    for (int k = 1; k <= 27; k++) begin
      chk = 1'b0;
      if (k == 24 || k == 26) begin
        addr = TB + 32'h8; wdata = 32'h7; we = 1'b1; sel = 4'hF;
      end else begin
        addr = TB; we = 1'b0; sel = 4'h0;
      end
      if (k == 11) begin exp_q.push_back(32'd2); chk = 1'b1; end
      if (k == 12) begin exp_q.push_back(32'd0); chk = 1'b1; end
      if (k == 24) begin exp_q.push_back(32'h0F); chk = 1'b1; end
      exp_int = (k >= 12) && (k < 26);
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (int4 !== exp_int) begin
        n_fail++; $display("FAIL auto_int_k%0d: got %b expected %b", k, int4, exp_int);
      end
      if (chk) begin
        e = exp_q.pop_front();
        n_checks++;
        if (rdata4 !== e) begin
          n_fail++; $display("FAIL auto_rdata_k%0d: got %h expected %h", k, rdata4, e);
        end
      end
    end
    we = 1'b0; sel = 4'h0;
  endtask

  task automatic test_reset_midrun;
    cyc_write(TB + 32'h8, 32'h0, 4'hF);
    cyc_write(TB, 32'h0, 4'hF);
    cyc_write(TB + 32'h4, 32'd100, 4'hF);
    cyc_write(TB + 32'h8, 32'h1, 4'hF);
    addr = TB;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rdata1 !== 32'd2) begin
      n_fail++; $display("FAIL midrun_count: got %h expected 2", rdata1);
    end
    resetn = 1'b0;
    #1;
    n_checks++;
    if (rdata1 !== 32'h0 || int1 !== 1'b0 || int4 !== 1'b0) begin
      n_fail++; $display("FAIL midrun_reset_count: got %h int=%b/%b expected 0 int=0/0", rdata1, int1, int4);
    end
    addr = TB + 32'h8;
    #1;
    n_checks++;
    if (rdata1 !== 32'h0 || rdata4 !== 32'h0) begin
      n_fail++; $display("FAIL midrun_reset_ctrl: got %h/%h expected 0", rdata1, rdata4);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask
`else
  task automatic test_timer_absent;
    cyc_write(TB + 32'h4, 32'd1, 4'hF);
    cyc_write(TB + 32'h8, 32'h1, 4'hF);
    addr = TB;
    repeat (10) @(negedge clk);
    n_checks++;
    if (int1 !== 1'b0 || int4 !== 1'b0 || rdata1 !== 32'h0 || bad1 !== 1'b1) begin
      n_fail++; $display("FAIL timer_absent: int=%b/%b rdata=%h bad=%b expected 0/0 0 1", int1, int4, rdata1, bad1);
    end
  endtask
`endif

  task automatic test_ram_retained;
    logic [31:0] e;
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    addr = RB + 32'h4; we = 1'b0; exp_q.push_back(model_rd(RB + 32'h4));
    @(negedge clk); e = exp_q.pop_front();
    n_checks++;
    if (rdata1 !== e || rdata4 !== e) begin
      n_fail++; $display("FAIL ram_retained_w1: got %h/%h expected %h", rdata1, rdata4, e);
    end
    addr = RB + RAM_BYTES - 32'h4; exp_q.push_back(model_rd(RB + RAM_BYTES - 32'h4));
    @(negedge clk); e = exp_q.pop_front();
    n_checks++;
    if (rdata1 !== e) begin
      n_fail++; $display("FAIL ram_retained_top: got %h expected %h", rdata1, e);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    resetn = 1'b0; addr = 32'h0; wdata = 32'h0; we = 1'b0; sel = 4'h0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    test_reset();
    test_byte_lanes();
    test_back_to_back();
    test_unmapped();
`ifdef DMEM_RESPONDER_TIMER_EN
    test_oneshot();
    test_count_write();
    test_auto_reload();
    test_reset_midrun();
`else
    test_timer_absent();
`endif
    test_ram_retained();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
